// File: rtl/leb128_window.sv
// leb128_window: byte-stream realigner that sits in front of the combinational
// LEB128 u64 unpacker.
//
// The block buffers incoming bytes in a shift-down queue. b[0] is always the
// first byte of the current encoded value, so w0..w9 give the unpacker a
// 10-byte window that is already aligned. When the consumer accepts a value,
// exactly w_len bytes are retired and the queue re-aligns to the next value.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   s_data/s_valid  incoming stream byte and its valid flag
//   s_ready         buffer can take a byte this cycle (cnt < DEPTH)
//   w0..w9          window bytes; w0 is the oldest byte; bytes past cnt read 0x00
//   w_valid         window holds a terminated value, or a malformed 10-byte run
//   w_len           byte count of the current value, 1..10
//   w_err           the first 10 buffered bytes all have the continuation bit set
//   w_ready         consumer takes the current value (ignored unless w_valid)
//   count           bytes currently buffered

// Next-state value for one queue slot: shift down by the pop amount, then
// optionally overwrite with the pushed byte.
module leb128_window_slot #(
  parameter int DEPTH = 16,
  parameter int IDX   = 0
) (
  input  logic [DEPTH-1:0][7:0]         q,
  input  logic [3:0]                    shamt,
  input  logic                          wr_en,
  input  logic [$clog2(DEPTH+1)-1:0]    wr_idx,
  input  logic [7:0]                    wr_data,
  output logic [7:0]                    d
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [IW:0] src;

  always_comb begin
    src = (IW+1)'(IDX) + (IW+1)'(shamt);
    d   = 8'h00;
    // Slots shifted in from beyond the end of storage become zero; they sit
    // above cnt anyway and are masked from the window.
    if (src < (IW+1)'(DEPTH)) d = q[src[IW-1:0]];
    if (wr_en && (wr_idx == CW'(IDX))) d = wr_data;
  end
endmodule

module leb128_window #(
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [7:0]                  w0,
  output logic [7:0]                  w1,
  output logic [7:0]                  w2,
  output logic [7:0]                  w3,
  output logic [7:0]                  w4,
  output logic [7:0]                  w5,
  output logic [7:0]                  w6,
  output logic [7:0]                  w7,
  output logic [7:0]                  w8,
  output logic [7:0]                  w9,
  output logic                        w_valid,
  output logic [3:0]                  w_len,
  output logic                        w_err,
  input  logic                        w_ready,
  output logic [$clog2(DEPTH+1)-1:0]  count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = 10;

  logic [DEPTH-1:0][7:0] b, b_next;
  logic [CW-1:0]         cnt, cnt_next, wr_idx;
  logic [NW-1:0][7:0]    win;
  logic                  push, pop, found, full_run;
  logic [3:0]            p, shamt;

  // No pass-through when full: a pop in the same cycle does not open space.
  assign s_ready = ~rst & (cnt < CW'(DEPTH));
  assign push    = s_valid & s_ready;
  assign pop     = w_valid & w_ready;
  assign count   = cnt;

  // Window: pad with zeros beyond the buffered bytes so stale slots never leak.
  genvar k;
  generate
    for (k = 0; k < NW; k++) begin : g_win
      assign win[k] = (cnt > CW'(k)) ? b[k] : 8'h00;
    end
  endgenerate

  assign {w9, w8, w7, w6, w5, w4, w3, w2, w1, w0} = win;

  // Terminator search: first buffered byte in the window with bit 7 clear.
  always_comb begin
    found = 1'b0;
    p     = 4'd0;
    for (int i = 0; i < NW; i++) begin
      if (!found && (CW'(i) < cnt) && !b[i][7]) begin
        found = 1'b1;
        p     = 4'(i);
      end
    end
  end

  assign full_run = (cnt >= CW'(NW));
  assign w_valid  = found | full_run;
  assign w_err    = ~found & full_run;
  assign w_len    = found ? (p + 4'd1) : (full_run ? 4'd10 : 4'd1);

  // w_len <= cnt whenever w_valid, so these never underflow.
  assign shamt    = pop ? w_len : 4'd0;
  assign wr_idx   = cnt - CW'(shamt);
  assign cnt_next = cnt + CW'(push) - CW'(shamt);

  genvar j;
  generate
    for (j = 0; j < DEPTH; j++) begin : g_slot
      leb128_window_slot #(.DEPTH(DEPTH), .IDX(j)) u_slot (
        .q       (b),
        .shamt   (shamt),
        .wr_en   (push),
        .wr_idx  (wr_idx),
        .wr_data (s_data),
        .d       (b_next[j])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      b   <= '0;
    end else begin
      cnt <= cnt_next;
      b   <= b_next;
    end
  end
endmodule

// File: tb/tb_leb128_window.sv
module tb_leb128_window;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    w0, w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic          w_valid;
  logic [3:0]    w_len;
  logic          w_err;
  logic          w_ready = 1'b0;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;

  leb128_window #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7),
    .w8(w8), .w9(w9), .w_valid(w_valid), .w_len(w_len), .w_err(w_err),
    .w_ready(w_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Reference LEB128 decode of the window, honouring the given length.
  function automatic logic [63:0] decode(input int len);
    logic [7:0]  wb [10];
    logic [63:0] v;
    wb = '{w0, w1, w2, w3, w4, w5, w6, w7, w8, w9};
    v  = 64'd0;
    for (int i = 0; i < len && i < 10; i++) v |= 64'(wb[i][6:0]) << (7 * i);
    return v;
  endfunction

  // Advance one clock; inputs and samples live 1 ns after the rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push1(input logic [7:0] d);
    s_data = d; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic pop1();
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; s_valid = 1'b0; w_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
    tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL rst_w_valid got %b want 0", w_valid); end
    tests++; if (w_len !== 4'd1) begin fails++; $display("FAIL rst_w_len got %0d want 1", w_len); end
    tests++; if (w_err !== 1'b0) begin fails++; $display("FAIL rst_w_err got %b want 0", w_err); end
    tests++; if (count !== 0) begin fails++; $display("FAIL rst_count got %0d want 0", count); end
    tests++; if (w0 !== 8'h00) begin fails++; $display("FAIL rst_w0 got %h want 00", w0); end
    @(negedge clk); rst = 1'b0;
    step();
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL post_rst_s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_three_byte();
    push1(8'hE5);
    tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL tb1_valid_early got %b want 0", w_valid); end
    push1(8'h8E);
    tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL tb2_valid_early got %b want 0", w_valid); end
    push1(8'h26);
    tests++; if (w_valid !== 1'b1) begin fails++; $display("FAIL tb3_valid got %b want 1", w_valid); end
    tests++; if ({w0, w1, w2, w3} !== 32'hE58E2600) begin fails++; $display("FAIL tb3_window got %h want e58e2600", {w0, w1, w2, w3}); end
    tests++; if (w_len !== 4'd3 || w_err !== 1'b0) begin fails++; $display("FAIL tb3_len_err got %0d/%b want 3/0", w_len, w_err); end
    tests++; if (decode(int'(w_len)) !== 64'd624485) begin fails++; $display("FAIL tb3_value got %0d want 624485", decode(int'(w_len))); end
    tests++; if (count !== 3) begin fails++; $display("FAIL tb3_count got %0d want 3", count); end
    pop1();
    tests++; if (count !== 0 || w_valid !== 1'b0) begin fails++; $display("FAIL tb3_pop got cnt %0d v %b want 0/0", count, w_valid); end
  endtask

  task automatic test_multi_pop();
    logic [3:0]  elen [3] = '{4'd1, 4'd1, 4'd2};
    logic [63:0] eval [3] = '{64'd0, 64'd127, 64'd128};
    push1(8'h00); push1(8'h7F); push1(8'h80); push1(8'h01);
    w_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (w_valid !== 1'b1 || w_len !== elen[i]) begin fails++; $display("FAIL multi_len%0d got v %b len %0d want 1/%0d", i, w_valid, w_len, elen[i]); end
      tests++; if (decode(int'(w_len)) !== eval[i]) begin fails++; $display("FAIL multi_val%0d got %0d want %0d", i, decode(int'(w_len)), eval[i]); end
      step();
    end
    w_ready = 1'b0;
    tests++; if (count !== 0 || w_valid !== 1'b0) begin fails++; $display("FAIL multi_end got cnt %0d v %b want 0/0", count, w_valid); end
  endtask

  task automatic test_malformed();
    for (int i = 0; i < 9; i++) push1(8'h80);
    tests++; if (w_valid !== 1'b0) begin fails++; $display("FAIL mal9_valid got %b want 0", w_valid); end
    // w_ready with no valid window must be ignored.
    pop1();
    tests++; if (count !== 9) begin fails++; $display("FAIL mal_ignore_count got %0d want 9", count); end
    push1(8'h80);
    tests++; if (w_valid !== 1'b1 || w_err !== 1'b1 || w_len !== 4'd10) begin fails++; $display("FAIL mal10 got v %b e %b len %0d want 1/1/10", w_valid, w_err, w_len); end
    pop1();
    tests++; if (count !== 0) begin fails++; $display("FAIL mal_pop_count got %0d want 0", count); end
    push1(8'h05);
    tests++; if (w_valid !== 1'b1 || w_len !== 4'd1 || w_err !== 1'b0 || w0 !== 8'h05) begin fails++; $display("FAIL mal_next got v %b len %0d e %b w0 %h want 1/1/0/05", w_valid, w_len, w_err, w0); end
    pop1();
  endtask

  task automatic test_fill();
    int acc = 0;
    s_data = 8'hFF; s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) acc++;
      step();
    end
    s_valid = 1'b0;
    tests++; if (acc !== 16) begin fails++; $display("FAIL fill_accepts got %0d want 16", acc); end
    tests++; if (count !== 16 || s_ready !== 1'b0) begin fails++; $display("FAIL fill_state got cnt %0d rdy %b want 16/0", count, s_ready); end
    tests++; if (w_err !== 1'b1 || w_len !== 4'd10) begin fails++; $display("FAIL fill_err got e %b len %0d want 1/10", w_err, w_len); end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    push1(8'hE5); push1(8'h8E); push1(8'h26);
    for (int i = 0; i < 13; i++) push1(8'hFF);
    tests++; if (count !== 16 || s_ready !== 1'b0 || w_len !== 4'd3) begin fails++; $display("FAIL full_pre got cnt %0d rdy %b len %0d want 16/0/3", count, s_ready, w_len); end
    s_data = 8'h11; s_valid = 1'b1; w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    tests++; if (count !== 13 || s_ready !== 1'b1) begin fails++; $display("FAIL full_pop got cnt %0d rdy %b want 13/1", count, s_ready); end
    step();
    s_valid = 1'b0;
    tests++; if (count !== 14 || w0 !== 8'hFF) begin fails++; $display("FAIL full_push got cnt %0d w0 %h want 14/ff", count, w0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push1(8'h01); push1(8'h02);
    s_data = 8'h03; s_valid = 1'b1; w_ready = 1'b1;
    step();
    s_valid = 1'b0; w_ready = 1'b0;
    tests++; if (count !== 2 || w0 !== 8'h02 || w1 !== 8'h03) begin fails++; $display("FAIL b2b got cnt %0d w0 %h w1 %h want 2/02/03", count, w0, w1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push1(8'hE5); push1(8'h8E);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    tests++; if (count !== 0 || s_ready !== 1'b0 || w_valid !== 1'b0) begin fails++; $display("FAIL rstmid got cnt %0d rdy %b v %b want 0/0/0", count, s_ready, w_valid); end
    @(negedge clk); rst = 1'b0;
    step();
    push1(8'h01);
    tests++; if (w_valid !== 1'b1 || w_len !== 4'd1 || w0 !== 8'h01 || count !== 1) begin fails++; $display("FAIL rstmid_after got v %b len %0d w0 %h cnt %0d want 1/1/01/1", w_valid, w_len, w0, count); end
  endtask

  initial begin
    #12;
    test_reset();
    test_three_byte();
    test_multi_pop();
    test_malformed();
    test_fill();
    test_full_pop_push();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
